// File: rtl/fixed_point_cmul_pipe.sv
// Pipelined signed fixed-point complex multiplier:
//   (a_re + j*a_im) * (b_re + j*b_im) -> (p_re + j*p_im), Q(WIDTH-FRAC).FRAC.
// Three register stages (products, exact sums, round/shift/saturate) with a
// single global advance enable, so the whole pipe stalls as one unit.
//
// Handshake: an operand set transfers on a rising edge where
// in_valid && in_ready; a result transfers where out_valid && out_ready.
// in_ready = !out_valid || out_ready, combinationally. When it is low every
// stage holds, bubbles included, and p_re/p_im/ovf stay stable until taken.
module fixed_point_cmul_pipe #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] p_re,
  output logic signed [WIDTH-1:0] p_im,
  output logic                    ovf
);

  // PW: full product, SW: exact sum of two products, FW: headroom for rounding.
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam int FW = 2 * WIDTH + 2;

  localparam logic signed [FW-1:0] RND_K =
    (ROUND != 0) ? (FW'(1) << (FRAC - 1)) : '0;
  localparam logic signed [FW-1:0] MAX_K =
    {{(FW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_K =
    {{(FW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 en;
  logic                 v1_q;
  logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
  logic                 v2_q;
  logic signed [SW-1:0] re_full_q, im_full_q;
  logic signed [SW-1:0] re_full_d, im_full_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     p_re_q, p_im_q, p_re_d, p_im_d;
  logic                 ovf_q, ovf_d, ovf_re, ovf_im;

  // Round, shift down by FRAC, then range-check; returns {overflow, value}.
  // Overflow is judged after rounding, so a rounding carry past max counts.
  function automatic logic [WIDTH:0] post(input logic signed [SW-1:0] full);
    logic signed [FW-1:0] ext;
    logic signed [FW-1:0] sh;
    logic                 o;
    logic [WIDTH-1:0]     v;
    ext = {full[SW-1], full} + RND_K;
    sh  = ext >>> FRAC;
    o   = (sh > MAX_K) || (sh < MIN_K);
    if (o && (SATURATE != 0)) v = sh[FW-1] ? SAT_MIN : SAT_MAX;
    else                      v = sh[WIDTH-1:0];
    return {o, v};
  endfunction

  // Global advance enable: the pipe moves whenever the output slot frees up.
  always_comb begin
    en = !out_valid_q || out_ready;
  end

  assign in_ready = en;

  // Stage-1 next values: four full-precision signed products.
  always_comb begin
    rr_d = PW'(a_re) * PW'(b_re);
    ii_d = PW'(a_im) * PW'(b_im);
    ri_d = PW'(a_re) * PW'(b_im);
    ir_d = PW'(a_im) * PW'(b_re);
  end

  // Stage-2 next values: exact sums with one extra bit so (-max)^2 twice fits.
  always_comb begin
    re_full_d = SW'(rr_q) - SW'(ii_q);
    im_full_d = SW'(ri_q) + SW'(ir_q);
  end

  // Stage-3 next values: rounding, scaling and saturation/wrap per component.
  always_comb begin
    {ovf_re, p_re_d} = post(re_full_q);
    {ovf_im, p_im_d} = post(im_full_q);
    ovf_d = ovf_re | ovf_im;
  end

  // Stage-1 register: products and their valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      rr_q <= rr_d;
      ii_q <= ii_d;
      ri_q <= ri_d;
      ir_q <= ir_d;
    end
  end

  // Stage-2 register: exact real/imag sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q      <= 1'b0;
      re_full_q <= '0;
      im_full_q <= '0;
    end else if (en) begin
      v2_q      <= v1_q;
      re_full_q <= re_full_d;
      im_full_q <= im_full_d;
    end
  end

  // Stage-3 register: final result, overflow flag and output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      p_re_q      <= '0;
      p_im_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= v2_q;
      p_re_q      <= p_re_d;
      p_im_q      <= p_im_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p_re      = p_re_q;
  assign p_im      = p_im_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_point_cmul_pipe.sv
// Bench for fixed_point_cmul_pipe: three instances sharing inputs and
// out_ready (round+sat, truncate+sat, round+wrap), a directed vector table,
// randomized streaming against an integer model, backpressure and reset.
module tb_fixed_point_cmul_pipe;

  localparam int W = 16;
  localparam int F = 8;

  typedef logic [2*W:0] res_t;  // {ovf, p_re, p_im}

  typedef struct {
    logic [W-1:0] ar, ai, br, bi;
    res_t         e0, e1, e2;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [2:0]   in_ready_w, out_valid_w, ovf_w;
  logic [W-1:0] p_re_w [3];
  logic [W-1:0] p_im_w [3];

  fixed_point_cmul_pipe #(.WIDTH(W), .FRAC(F), .ROUND(1), .SATURATE(1)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .p_re(p_re_w[0]), .p_im(p_im_w[0]), .ovf(ovf_w[0]));

  fixed_point_cmul_pipe #(.WIDTH(W), .FRAC(F), .ROUND(0), .SATURATE(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .p_re(p_re_w[1]), .p_im(p_im_w[1]), .ovf(ovf_w[1]));

  fixed_point_cmul_pipe #(.WIDTH(W), .FRAC(F), .ROUND(1), .SATURATE(0)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .p_re(p_re_w[2]), .p_im(p_im_w[2]), .ovf(ovf_w[2]));

  // ---------------- bookkeeping ----------------
  int   checks = 0;
  int   errors = 0;
  int   pops0  = 0;
  logic rand_rdy = 1'b0;
  res_t exp0_q[$];
  res_t exp1_q[$];
  res_t exp2_q[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W:0] post(input longint full, input int rnd, input int sat);
    longint       v, maxv, minv;
    logic         o;
    logic [W-1:0] val;
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    v = full;
    if (rnd != 0) v = v + (longint'(1) <<< (F - 1));
    v = v >>> F;
    o = (v > maxv) || (v < minv);
    if (o && sat != 0) val = (v < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else               val = v[W-1:0];
    return {o, val};
  endfunction

  function automatic res_t model(input logic [W-1:0] ar, ai, br, bi, input int rnd, input int sat);
    longint     xr, xi, yr, yi;
    logic [W:0] r, i;
    xr = longint'($signed(ar));
    xi = longint'($signed(ai));
    yr = longint'($signed(br));
    yi = longint'($signed(bi));
    r = post(xr * yr - xi * yi, rnd, sat);
    i = post(xr * yi + xi * yr, rnd, sat);
    return {r[W] | i[W], r[W-1:0], i[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] ar, ai, br, bi, input res_t e0, e1, e2);
    int ok;
    ok = 0;
    in_valid = 1'b1;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    for (int t = 0; t < 60 && ok == 0; t++) begin
      @(negedge clk);
      if (in_ready_w[0]) begin
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
        exp2_q.push_back(e2);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok == 0) cmp("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_model(input logic [W-1:0] ar, ai, br, bi);
    send(ar, ai, br, bi, model(ar, ai, br, bi, 1, 1), model(ar, ai, br, bi, 0, 1),
         model(ar, ai, br, bi, 1, 0));
  endtask

  // Cycles from the accepting edge (counted as 1) until out_valid is seen.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid_w[0] && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 300 && (exp0_q.size() + exp1_q.size() + exp2_q.size()) != 0; t++)
      @(posedge clk);
    @(posedge clk); #1;
    cmp(name, 64'(exp0_q.size() + exp1_q.size() + exp2_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // Random downstream backpressure while enabled.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard ----------------
  // Every valid output cycle, stalled or not, must equal the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_w[0]) begin
        if (exp0_q.size() == 0) cmp("d0_spurious_valid", 64'(out_valid_w[0]), 64'd0);
        else begin
          cmp("d0_result", 64'({ovf_w[0], p_re_w[0], p_im_w[0]}), 64'(exp0_q[0]));
          if (out_ready) begin void'(exp0_q.pop_front()); pops0++; end
        end
      end
      if (out_valid_w[1]) begin
        if (exp1_q.size() == 0) cmp("d1_spurious_valid", 64'(out_valid_w[1]), 64'd0);
        else begin
          cmp("d1_result", 64'({ovf_w[1], p_re_w[1], p_im_w[1]}), 64'(exp1_q[0]));
          if (out_ready) void'(exp1_q.pop_front());
        end
      end
      if (out_valid_w[2]) begin
        if (exp2_q.size() == 0) cmp("d2_spurious_valid", 64'(out_valid_w[2]), 64'd0);
        else begin
          cmp("d2_result", 64'({ovf_w[2], p_re_w[2], p_im_w[2]}), 64'(exp2_q[0]));
          if (out_ready) void'(exp2_q.pop_front());
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  vec_t vecs[9];

  initial begin
    int cyc;
    int pops_start;

    vecs[0] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000,
                {1'b0,16'h0100,16'h0000}, {1'b0,16'h0100,16'h0000}, {1'b0,16'h0100,16'h0000}};
    vecs[1] = '{16'h0000, 16'h0100, 16'h0000, 16'h0100,
                {1'b0,16'hFF00,16'h0000}, {1'b0,16'hFF00,16'h0000}, {1'b0,16'hFF00,16'h0000}};
    vecs[2] = '{16'h0200, 16'h0100, 16'h0100, 16'hFF00,
                {1'b0,16'h0300,16'hFF00}, {1'b0,16'h0300,16'hFF00}, {1'b0,16'h0300,16'hFF00}};
    vecs[3] = '{16'h0001, 16'h0000, 16'h0080, 16'h0000,
                {1'b0,16'h0001,16'h0000}, {1'b0,16'h0000,16'h0000}, {1'b0,16'h0001,16'h0000}};
    vecs[4] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000,
                {1'b0,16'h0000,16'h0000}, {1'b0,16'hFFFF,16'h0000}, {1'b0,16'h0000,16'h0000}};
    vecs[5] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
                {1'b1,16'h0000,16'h7FFF}, {1'b1,16'h0000,16'h7FFF}, {1'b1,16'h0000,16'h0000}};
    vecs[6] = '{16'h7F00, 16'h0000, 16'h7F00, 16'h0000,
                {1'b1,16'h7FFF,16'h0000}, {1'b1,16'h7FFF,16'h0000}, {1'b1,16'h0100,16'h0000}};
    vecs[7] = '{16'h7F80, 16'h0000, 16'h0101, 16'h0000,
                {1'b1,16'h7FFF,16'h0000}, {1'b0,16'h7FFF,16'h0000}, {1'b1,16'h8000,16'h0000}};
    vecs[8] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000,
                {1'b1,16'h8000,16'h0000}, {1'b1,16'h8000,16'h0000}, {1'b1,16'h0080,16'h0000}};

    // Reset: asserted asynchronously, checked while held.
    #1 rst = 1'b1;
    #1;
    cmp("rst_out_valid", 64'(out_valid_w), 64'd0);
    cmp("rst_in_ready",  64'(in_ready_w), 64'h7);
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_p_re",  64'(p_re_w[0]), 64'd0);
    cmp("rst_p_im",  64'(p_im_w[0]), 64'd0);
    cmp("rst_ovf",   64'(ovf_w), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    cmp("post_rst_in_ready", 64'(in_ready_w[0]), 64'd1);

    // Directed table: one vector at a time, latency checked each time.
    for (int k = 0; k < 9; k++) begin
      send(vecs[k].ar, vecs[k].ai, vecs[k].br, vecs[k].bi, vecs[k].e0, vecs[k].e1, vecs[k].e2);
      wait_out(cyc);
      cmp($sformatf("vec%0d_latency", k), 64'(cyc), 64'd3);
      @(posedge clk); #1;
    end
    drain("table_drain");

    // Randomized stream with random gaps and random backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send_model(rnd_op(), rnd_op(), rnd_op(), rnd_op());
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain("random_drain");

    // Backpressure: 6 back-to-back, output held for 5 cycles after first result.
    @(posedge clk); #1;
    pops_start = pops0;
    fork
      begin
        for (int n = 0; n < 6; n++) send_model(rnd_op(), rnd_op(), rnd_op(), rnd_op());
      end
      begin
        int t;
        t = 0;
        while (!out_valid_w[0] && t < 30) begin @(posedge clk); #1; t++; end
        cmp("bp_first_out", 64'(out_valid_w[0]), 64'd1);
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          cmp("bp_in_ready_low", 64'(in_ready_w), 64'd0);
          cmp("bp_out_valid_held", 64'(out_valid_w), 64'h7);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    cmp("bp_delivered", 64'(pops0 - pops_start), 64'd6);

    // Reset with two items in flight, one of them parked at the output.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_model(16'h0123, 16'h0456, 16'hF789, 16'h0ABC);
    send_model(16'h1111, 16'hEEEE, 16'h2222, 16'hDDDD);
    wait_out(cyc);
    cmp("mid_pre_valid", 64'(out_valid_w[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    cmp("mid_rst_out_valid", 64'(out_valid_w), 64'd0);
    cmp("mid_rst_p", 64'({p_re_w[0], p_im_w[0]}), 64'd0);
    cmp("mid_rst_ovf", 64'(ovf_w), 64'd0);
    cmp("mid_rst_in_ready", 64'(in_ready_w), 64'h7);
    exp0_q.delete();
    exp1_q.delete();
    exp2_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 6; n++) begin
      cmp("mid_no_stale", 64'(out_valid_w[0]), 64'd0);
      @(posedge clk); #1;
    end
    send_model(16'h0180, 16'hFF40, 16'h0200, 16'h0040);
    wait_out(cyc);
    cmp("mid_new_latency", 64'(cyc), 64'd3);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_point_cmul_pipe.md
Name: fixed_point_cmul_pipe

Overview:
- Pipelined, parametrised signed fixed-point complex multiplier for amplitude arithmetic in gate-application datapaths: (a_re + j·a_im) × (b_re + j·b_im).
- Successor to the combinational Q8.8 real multiplier, generalised in width, fraction bits, rounding and saturation.
- Adds a valid/ready streaming interface with whole-pipeline stall, and an overflow flag.
- Sits between the state-vector memory reader and the accumulate stage.

Parameters:
- WIDTH, 16, total bits per signed component (two's complement); legal range 4..32.
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC); legal range 1..WIDTH-1.
- ROUND, 1, 0 = truncate (arithmetic shift, toward -inf); 1 = round half up (add 2^(FRAC-1) before shift).
- SATURATE, 1, 0 = wrap (keep low WIDTH bits); 1 = clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block accepts operands this cycle.
- a_re, a_im, b_re, b_im  in  WIDTH each  signed operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- p_re, p_im  out  WIDTH each  signed result components.
- ovf  out  1  result overflowed WIDTH in either component (saturated or wrapped); qualified by out_valid.

Behaviour:
- Reset: all stage valid bits clear; out_valid=0, p_re=0, p_im=0, ovf=0. in_ready=1 during and after reset. Reset mid-operation discards all in-flight data.
- Pipeline: 3 register stages, latency exactly 3 cycles from accepted input to out_valid with no stall.
  - S1 registers the four products a_re·b_re, a_im·b_im, a_re·b_im, a_im·b_re, each signed 2·WIDTH bits.
  - S2 registers re_full = rr − ii and im_full = ri + ir, each signed 2·WIDTH+1 bits, with no intermediate truncation.
  - S3 rounds per ROUND, arithmetic-shifts right by FRAC, then saturates or wraps per SATURATE. Registers p_re, p_im, ovf, out_valid.
- Handshake:
  - Global advance enable en = !out_valid || out_ready; in_ready = en (combinational).
  - Input is accepted when in_valid && in_ready.
  - When en=0 all stages hold, including empty bubble stages. No data is lost, duplicated or reordered.
  - Bubbles propagate as valid=0. Data registers may hold stale values when valid=0.
  - While out_valid && !out_ready, p_re, p_im and ovf are stable.
- Throughput: one result per cycle while out_ready=1.
- Overflow: ovf = 1 if the shifted value of re or im lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. This is evaluated after rounding, and ovf is set regardless of SATURATE.
- Rounding boundary: a rounding carry that pushes a value past the max positive is an overflow.
- Corner case: (-2^(WIDTH-1))·(-2^(WIDTH-1)) summed twice requires the extra sum bit. im_full must not wrap internally.

Test Plan:
- Defaults (Q8.8): a=(0x0100,0x0000), b=(0x0100,0x0000), out_ready=1 -> 3 cycles later p=(0x0100,0x0000), ovf=0.
- a=(0,0x0100) (i), b=(0,0x0100) -> p=(0xFF00,0x0000) (−1); a=(0x0200,0x0100), b=(0x0100,0xFF00) -> p=(0x0300,0xFF00).
- Rounding, a_re=0x0001, b_re=0x0080, imag parts 0:
  - ROUND=1 -> p_re=0x0001.
  - ROUND=0 -> p_re=0x0000.
  - a_re=0xFFFF with ROUND=0 -> p_re=0xFFFF.
  - a_re=0xFFFF with ROUND=1 -> p_re=0x0000.
- Overflow, all components 0x8000:
  - SATURATE=1 -> p=(0x0000,0x7FFF), ovf=1.
  - SATURATE=0 -> p_im=low 16 bits of 2^23 = 0x0000, ovf=1.
  - a_re=b_re=0x7F00 -> p_re=0x7FFF, ovf=1.
- Backpressure: stream 6 back-to-back operand sets, hold out_ready=0 for 5 cycles after first out_valid -> in_ready=0 during the hold, outputs held stable, all 6 results delivered in order, none dropped or duplicated.
- Reset: assert rst asynchronously with 2 items in flight -> out_valid drops to 0 immediately. After release, no stale result emerges, and a new input yields its result 3 cycles after acceptance.
